// File: rtl/sequence_serializer.sv
// Parallel-to-serial converter feeding a bit-serial sequence detector.
// Words enter a one-entry holding buffer and are shifted out MSB first,
// optionally followed by a fixed number of idle bit times.
//
// state | meaning
// IDLE  | nothing shifting; waits for the holding buffer to fill
// SHIFT | one data bit per cycle on sequence_out, MSB first
// GAP   | GAP_CYCLES idle bit times after a word
module sequence_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             accept;
  logic             drain;

  // ready only looks at registered buffer state and reset, never at data_valid
  assign data_ready = !buf_full_q && !reset;
  assign accept     = data_valid && data_ready;

  // registered state: FSM, holding buffer, shifter and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // next-state logic; drain (buffer -> shifter) and accept are mutually
  // exclusive because drain needs a full buffer and accept an empty one
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    drain      = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          drain   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else if (buf_full_q) begin
            drain = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (gap_cnt_q == GAP_LAST) begin
          if (buf_full_q) begin
            drain   = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (drain) begin
      shift_d    = buf_q;
      bit_cnt_d  = '0;
      buf_full_d = 1'b0;
    end else if (accept) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end
  end

  // outputs decoded purely from registers
  always_comb begin
    bit_valid    = (state_q == SHIFT);
    sequence_out = bit_valid && shift_q[WIDTH-1];
    word_done    = bit_valid && (bit_cnt_q == BIT_LAST);
    busy         = (state_q != IDLE) || buf_full_q;
  end

endmodule

// File: tb/tb_sequence_serializer.sv
// Bench for sequence_serializer: two instances (8-bit no gap, 4-bit gap 2)
// checked every cycle against a timeline model, plus literal waveforms.
module tb_sequence_serializer;

  localparam int NC = 8192;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       val [2];
  logic [7:0] din [2];
  logic       rdy [2];
  logic       so  [2];
  logic       bv  [2];
  logic       wd  [2];
  logic       bz  [2];

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // expected outputs per instance, indexed by the cycle following edge k
  bit e_so [2][NC];
  bit e_bv [2][NC];
  bit e_wd [2][NC];
  bit e_bz [2][NC];
  int pa [2];   // edge at which the buffered word was accepted
  int pd [2];   // edge at which it leaves the buffer
  int fr [2];   // first edge at which the shifter can take a new word
  bit acc [2];

  always #5 clock = ~clock;

  sequence_serializer #(.WIDTH(8), .GAP_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .data_in(din[0]), .data_valid(val[0]),
    .data_ready(rdy[0]), .sequence_out(so[0]), .bit_valid(bv[0]),
    .word_done(wd[0]), .busy(bz[0]));

  sequence_serializer #(.WIDTH(4), .GAP_CYCLES(2)) dut_b (
    .clock(clock), .reset(reset), .data_in(din[1][3:0]), .data_valid(val[1]),
    .data_ready(rdy[1]), .sequence_out(so[1]), .bit_valid(bv[1]),
    .word_done(wd[1]), .busy(bz[1]));

  function automatic int wof(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int gof(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic bit buf_full_m(int i, int c);
    return (c >= pa[i]) && (c < pd[i]);
  endfunction

  task automatic check(input string name, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, i, edge_n, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // timeline model: a word accepted at edge k starts shifting at
  // max(k+1, line free), occupies W bit cycles then G idle cycles
  task automatic model_edge(input int i);
    int k, d, w, g;
    k = edge_n;
    w = wof(i);
    g = gof(i);
    acc[i] = 1'b0;
    if (reset) begin
      for (int c = k; c < NC; c++) begin
        e_so[i][c] = 1'b0; e_bv[i][c] = 1'b0; e_wd[i][c] = 1'b0; e_bz[i][c] = 1'b0;
      end
      fr[i] = k; pa[i] = k; pd[i] = k;
    end else if (val[i] && !buf_full_m(i, k - 1)) begin
      d = (k + 1 > fr[i]) ? k + 1 : fr[i];
      for (int j = 0; j < w; j++) begin
        e_so[i][d + j] = din[i][w - 1 - j];
        e_bv[i][d + j] = 1'b1;
      end
      e_wd[i][d + w - 1] = 1'b1;
      for (int c = k; c < d + w + g; c++) e_bz[i][c] = 1'b1;
      fr[i] = d + w + g;
      pa[i] = k;
      pd[i] = d;
      acc[i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    edge_n++;
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  // per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("sequence_out", i, so[i], e_so[i][edge_n]);
        check("bit_valid",    i, bv[i], e_bv[i][edge_n]);
        check("word_done",    i, wd[i], e_wd[i][edge_n]);
        check("busy",         i, bz[i], e_bz[i][edge_n]);
        check("data_ready",   i, rdy[i], !reset && !buf_full_m(i, edge_n));
      end
    end
  end

  logic [15:0] a_so, a_wd, a_bv, b_so, b_bv;
  int na, nb, a0;
  logic any_bv;

  initial begin
    for (int i = 0; i < 2; i++) begin
      val[i] = 1'b0; din[i] = 8'h00; pa[i] = 0; pd[i] = 0; fr[i] = 0; acc[i] = 1'b0;
    end
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clock);
    check("ready_during_reset", 0, rdy[0], 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 0, rdy[0], 1'b1);
    check("busy_after_reset", 0, bz[0], 1'b0);

    // single word 8'hB2 one cycle after reset release
    val[0] = 1'b1; din[0] = 8'hB2;
    tick();
    val[0] = 1'b0;
    a_so = '0; a_wd = '0; a_bv = '0;
    for (int t = 0; t < 8; t++) begin
      tick();
      @(negedge clock);
      a_so[7 - t] = so[0]; a_wd[7 - t] = wd[0]; a_bv[7 - t] = bv[0];
    end
    check_vec("single_word_bits", a_so, 16'h00B2);
    check_vec("single_word_done", a_wd, 16'h0001);
    check_vec("single_word_valid", a_bv, 16'h00FF);
    tick();
    @(negedge clock);
    check("idle_after_word_bv", 0, bv[0], 1'b0);
    check("idle_after_word_busy", 0, bz[0], 1'b0);

    // back-to-back pairs on both instances
    val[0] = 1'b1; din[0] = 8'hB2;
    val[1] = 1'b1; din[1] = 8'h0B;
    na = 0; nb = 0;
    a_so = '0; a_wd = '0; b_so = '0; b_bv = '0;
    for (int t = -1; t < 16; t++) begin
      tick();
      if (acc[0]) begin na++; if (na == 1) din[0] = 8'h0F; else val[0] = 1'b0; end
      if (acc[1]) begin nb++; if (nb == 1) din[1] = 8'h05; else val[1] = 1'b0; end
      @(negedge clock);
      if (t >= 0) begin
        a_so[15 - t] = so[0];
        a_wd[15 - t] = wd[0];
        if (t < 10) begin
          b_so[9 - t] = so[1];
          b_bv[9 - t] = bv[1];
        end
      end
    end
    check_vec("stream_a_bits", a_so, 16'b1011001000001111);
    check_vec("stream_a_done", a_wd, 16'b0000000100000001);
    check_vec("stream_b_bits", b_so, 16'b0000001011000101);
    check_vec("stream_b_valid", b_bv, 16'b0000001111001111);

    // reset during the 4th bit of 8'hFF with 8'h5A buffered
    repeat (12) tick();
    val[0] = 1'b1; din[0] = 8'hFF;
    tick();
    a0 = edge_n;
    din[0] = 8'h5A;
    for (int t = 0; t < 6 && !acc[0]; t++) tick();
    val[0] = 1'b0;
    for (int t = 0; t < 8 && edge_n < a0 + 4; t++) tick();
    reset = 1'b1;
    @(negedge clock);
    check("fourth_bit_visible", 0, bv[0], 1'b1);
    check("ready_low_in_reset", 0, rdy[0], 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_seq", 0, so[0], 1'b0);
    check("post_reset_bv", 0, bv[0], 1'b0);
    check("post_reset_busy", 0, bz[0], 1'b0);
    check("post_reset_ready", 0, rdy[0], 1'b1);
    any_bv = 1'b0;
    repeat (20) begin
      tick();
      @(negedge clock);
      any_bv = any_bv | bv[0];
    end
    check("no_residual_bits", 0, any_bv, 1'b0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 2500 && edge_n + 64 < NC; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (reset || acc[i] || !val[i]) begin
          val[i] = ($urandom_range(0, 99) < 60);
          din[i] = 8'($urandom);
        end
      end
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    val[0] = 1'b0; val[1] = 1'b0;
    repeat (30) tick();
    @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_serializer.md
SEQUENCE_SERIALIZER -- requirements
Module: sequence_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits per word; legal range 2..32.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 0, giving the number of idle (0) bit times inserted after every word; legal range 0..255.
REQ-003 clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_in  input  WIDTH  parallel word to serialize, MSB transmitted first.
REQ-006 data_valid  input  1  upstream asserts when data_in holds a word.
REQ-007 data_ready  output  1  high when the holding buffer can accept a word.
REQ-008 sequence_out  output  1  serial bit stream feeding the sequence detector's sequence_in.
REQ-009 bit_valid  output  1  high in cycles where sequence_out carries a data bit.
REQ-010 word_done  output  1  single-cycle pulse coincident with the last bit of each word.
REQ-011 busy  output  1  high when a word is shifting, a gap is in progress, or the buffer is full.

Function
REQ-012 A word SHALL be accepted on a rising edge where data_valid and data_ready are both 1; data_in SHALL be sampled only at that edge.
REQ-013 Accepted words SHALL go to a one-entry holding buffer (buf, buf_full); data_ready SHALL equal not buf_full and not reset, and SHALL not depend combinationally on data_valid.
REQ-014 FSM states SHALL be IDLE, SHIFT, GAP; sequence_out, bit_valid, word_done, busy SHALL be decoded from registers only.
REQ-015 IDLE: if buf_full, next edge SHALL load shift register from buf, clear buf_full, bit counter to 0, go to SHIFT; else stay IDLE.
REQ-016 SHIFT: sequence_out SHALL equal shift-register MSB, bit_valid 1; each edge SHALL shift left one bit and increment counter.
REQ-017 word_done SHALL be 1 exactly in the SHIFT cycle where counter equals WIDTH-1.
REQ-018 At the last-bit edge: GAP_CYCLES>0 -> GAP with gap counter 0; GAP_CYCLES=0 and buf_full -> reload from buf, clear buf_full, stay SHIFT (no bubble); otherwise -> IDLE.
REQ-019 GAP: sequence_out 0, bit_valid 0 for exactly GAP_CYCLES cycles, then reload-and-SHIFT if buf_full, else IDLE.
REQ-020 In IDLE and GAP, sequence_out and bit_valid SHALL be 0.
REQ-021 Latency: word accepted at edge N (buffer empty, FSM IDLE) SHALL present its MSB on sequence_out in the cycle after edge N+1.
REQ-022 Buffer drain and refill SHALL not occur on the same edge; a word offered while buf_full SHALL wait, with data_in held by upstream.
REQ-023 With GAP_CYCLES=0 and upstream always valid, the stream SHALL be continuous (bit_valid constantly 1 after the first bit).
REQ-024 busy SHALL equal (state != IDLE) or buf_full.

Reset
REQ-025 On an edge with reset=1: state IDLE, buf_full 0, shift register 0, counters 0; following cycle sequence_out=0, bit_valid=0, word_done=0, busy=0.
REQ-026 data_ready SHALL be 0 while reset is 1 and 1 in the first cycle after reset deasserts.
REQ-027 Reset mid-word or mid-gap SHALL discard the partial word and any buffered word; no residual bits SHALL appear after reset.

Verification
REQ-028 WIDTH=8, GAP=0: accept 8'hB2 one cycle after reset -> sequence_out 1,0,1,1,0,0,1,0 from 2 cycles after accept, bit_valid 1 for 8 cycles, word_done on 8th bit only, then IDLE.
REQ-029 WIDTH=8, GAP=0, data_valid held 1 with 8'hB2 then 8'h0F -> 16 contiguous bits 1011001000001111, word_done at bits 8 and 16, data_ready low only while buffer full.
REQ-030 WIDTH=4, GAP=2: words 4'hB, 4'h5 back-to-back -> 1011,0,0,0101 with bit_valid 0 for exactly 2 gap cycles.
REQ-031 Reset asserted at 4th bit of 8'hFF with a buffered word -> sequence_out 0 next cycle, buffer empty, no further bits; data_ready 1 after release.
REQ-032 Chained into sequence_pattern_detector_Moore: stream containing the detector's target pattern -> detector_out asserts exactly once per occurrence at the cycle the detector spec defines.
